// File: rtl/uba_intr_pkg.sv
// Shared types and constants for the Unibus device interrupt requester.
// The one-hot masks map a BR level (7..4) onto the devINTR/devINTA bit layout [7:4].
package uba_intr_pkg;

  localparam int VECT_W = 18;
  localparam int IDX_W  = 3;

  localparam logic [3:0] INTR7 = 4'b1000;
  localparam logic [3:0] INTR6 = 4'b0100;
  localparam logic [3:0] INTR5 = 4'b0010;
  localparam logic [3:0] INTR4 = 4'b0001;
  localparam logic [3:0] NUL   = 4'b0000;

  typedef enum logic [1:0] {IDLE, REQ, VEC} state_t;

  function automatic logic [3:0] level_mask(input int level);
    case (level)
      7:       return INTR7;
      6:       return INTR6;
      5:       return INTR5;
      4:       return INTR4;
      default: return NUL;
    endcase
  endfunction

endpackage

// File: rtl/uba_intr_prienc.sv
// Lowest-index-wins priority encoder over the eligible pending sources.
// Purely combinational; idx is meaningful only while valid is high.
module uba_intr_prienc
  import uba_intr_pkg::*;
#(
  parameter int N = 2
) (
  input  logic [N-1:0]     req,
  output logic [IDX_W-1:0] idx,
  output logic             valid
);

  // Scan from the top down so the lowest set index is the last one written.
  always_comb begin
    idx   = '0;
    valid = |req;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) idx = IDX_W'(i);
    end
  end

endmodule

// File: rtl/uba_dev_intr.sv
// Device-side Unibus interrupt requester: pending flags, BR request, vector on INTA.
// Optional VEC-state acknowledge timeout with statTMO output when UBA_DEV_INTR_TMO_EN is defined.
module uba_dev_intr
  import uba_intr_pkg::*;
#(
  parameter int                NUM_SRC   = 2,
  parameter int                BR_LEVEL  = 5,
  parameter logic [VECT_W-1:0] VECT_BASE = 18'o000300
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_SRC-1:0] srcEVT,
  input  logic [NUM_SRC-1:0] srcIE,
  output logic [7:4]         devINTR,
  input  logic [7:4]         devINTA,
  output logic [VECT_W-1:0]  devVECT,
  output logic               devVECTV,
  output logic [NUM_SRC-1:0] srcACK,
  output logic [NUM_SRC-1:0] statPEND
`ifdef UBA_DEV_INTR_TMO_EN
  ,
  output logic               statTMO
`endif
);

  state_t              state_q, state_d;
  logic [NUM_SRC-1:0]  pend_q, pend_d, elig, ack_d, ack_q;
  logic [IDX_W-1:0]    gidx;
  logic                gvalid, inta, grant;
  logic [VECT_W-1:0]   vsum, vect_d, vect_q;
  logic                vectv_d, vectv_q, intr_d, intr_q;
  logic                inta_unused;
`ifdef UBA_DEV_INTR_TMO_EN
  logic [7:0]          tmo_cnt;
  logic                tmo_hit, tmo_q;
`endif

  assign inta        = devINTA[BR_LEVEL];
  assign inta_unused = ^devINTA;
  // A source whose enable drops in the acknowledge cycle is not granted.
  assign elig        = pend_q & srcIE;
  assign vsum        = VECT_BASE + (VECT_W'(gidx) << 2);

  uba_intr_prienc #(.N(NUM_SRC)) u_prienc (
    .req   (elig),
    .idx   (gidx),
    .valid (gvalid)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      pend_q   <= '0;
      ack_q    <= '0;
      vect_q   <= '0;
      vectv_q  <= 1'b0;
      intr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      pend_q   <= pend_d;
      ack_q    <= ack_d;
      vect_q   <= vect_d;
      vectv_q  <= vectv_d;
      intr_q   <= intr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    grant   = 1'b0;
`ifdef UBA_DEV_INTR_TMO_EN
    tmo_hit = 1'b0;
`endif
    case (state_q)
      IDLE: if (|pend_q) state_d = REQ;
      // An INTA with nothing eligible still enters VEC, but passively.
      REQ: begin
        if (inta) begin
          state_d = VEC;
          grant   = gvalid;
        end else if (!(|pend_q)) begin
          state_d = IDLE;
        end
      end
      VEC: begin
        if (!inta) begin
          state_d = IDLE;
`ifdef UBA_DEV_INTR_TMO_EN
        end else if (tmo_cnt == 8'd254) begin
          state_d = IDLE;
          tmo_hit = 1'b1;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Set beats grant-clear; a dropped enable beats everything.
  always_comb begin
    vect_d  = vect_q;
    vectv_d = vectv_q;
    for (int i = 0; i < NUM_SRC; i++) ack_d[i] = grant && (gidx == IDX_W'(i));
    if (grant) begin
      vect_d  = {vsum[VECT_W-1:2], 2'b00};
      vectv_d = 1'b1;
    end else if (state_d != VEC) begin
      vect_d  = '0;
      vectv_d = 1'b0;
    end
    pend_d = srcIE & (srcEVT | (pend_q & ~ack_d));
    intr_d = (state_d != VEC) && (|pend_d);
  end

`ifdef UBA_DEV_INTR_TMO_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tmo_cnt <= '0;
      tmo_q   <= 1'b0;
    end else begin
      tmo_cnt <= (state_q == VEC) ? tmo_cnt + 8'd1 : 8'd0;
      tmo_q   <= tmo_hit;
    end
  end

  assign statTMO = tmo_q;
`endif

  assign devINTR  = intr_q ? level_mask(BR_LEVEL) : NUL;
  assign devVECT  = vect_q;
  assign devVECTV = vectv_q;
  assign srcACK   = ack_q;
  assign statPEND = pend_q;

endmodule

// File: tb/tb_uba_dev_intr.sv
// Directed bench for uba_dev_intr at default parameters (NUM_SRC=2, BR_LEVEL=5, base 0o300).
// The timeout sequence is included when UBA_DEV_INTR_TMO_EN is defined.
module tb_uba_dev_intr;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  srcEVT, srcIE, srcACK, statPEND;
  logic [7:4]  devINTR, devINTA;
  logic [17:0] devVECT;
  logic        devVECTV;
`ifdef UBA_DEV_INTR_TMO_EN
  logic        statTMO;
`endif
  int          testsRun = 0;
  int          testsFailed = 0;

  uba_dev_intr dut (
    .clk      (clk),
    .rst      (rst),
    .srcEVT   (srcEVT),
    .srcIE    (srcIE),
    .devINTR  (devINTR),
    .devINTA  (devINTA),
    .devVECT  (devVECT),
    .devVECTV (devVECTV),
    .srcACK   (srcACK),
    .statPEND (statPEND)
`ifdef UBA_DEV_INTR_TMO_EN
    ,
    .statTMO  (statTMO)
`endif
  );

  always #5 clk = ~clk;

  task automatic applyStimulus(input logic [1:0] evt, input logic [1:0] ie, input logic [7:4] inta);
    srcEVT  = evt;
    srcIE   = ie;
    devINTA = inta;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testsRun++;
    assert (observed === expected) else begin
      testsFailed++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  initial begin
    rst = 1'b0; srcEVT = 2'b00; srcIE = 2'b00; devINTA = 4'b0000;
    #3;
    checkOutput("reset_intr", 32'(devINTR), 32'h0);
    checkOutput("reset_vect", 32'(devVECT), 32'h0);
    checkOutput("reset_vectv", 32'(devVECTV), 32'h0);
    checkOutput("reset_ack", 32'(srcACK), 32'h0);
    checkOutput("reset_pend", 32'(statPEND), 32'h0);
    #10 rst = 1'b1;

    // Single event on source 1
    applyStimulus(2'b10, 2'b11, 4'b0000);
    checkOutput("s1_intr", 32'(devINTR), 32'(4'b0010));
    checkOutput("s1_pend", 32'(statPEND), 32'(2'b10));
    applyStimulus(2'b00, 2'b11, 4'b0000);
    checkOutput("s1_intr_req", 32'(devINTR), 32'(4'b0010));
    applyStimulus(2'b00, 2'b11, 4'b0010);
    checkOutput("s1_vect", 32'(devVECT), 32'(18'o000304));
    checkOutput("s1_vectv", 32'(devVECTV), 32'h1);
    checkOutput("s1_ack", 32'(srcACK), 32'(2'b10));
    checkOutput("s1_pend_clr", 32'(statPEND), 32'h0);
    checkOutput("s1_intr_vec", 32'(devINTR), 32'h0);
    applyStimulus(2'b00, 2'b11, 4'b0010);
    checkOutput("s1_ack_pulse", 32'(srcACK), 32'h0);
    checkOutput("s1_vect_hold", 32'(devVECT), 32'(18'o000304));
    applyStimulus(2'b00, 2'b11, 4'b0000);
    checkOutput("s1_vect_drop", 32'(devVECT), 32'h0);
    checkOutput("s1_vectv_drop", 32'(devVECTV), 32'h0);
    checkOutput("s1_intr_drop", 32'(devINTR), 32'h0);

    // Both sources at once: 0 first, then 1
    applyStimulus(2'b11, 2'b11, 4'b0000);
    checkOutput("s2_pend", 32'(statPEND), 32'(2'b11));
    applyStimulus(2'b00, 2'b11, 4'b0000);
    applyStimulus(2'b00, 2'b11, 4'b0010);
    checkOutput("s2_vect0", 32'(devVECT), 32'(18'o000300));
    checkOutput("s2_ack0", 32'(srcACK), 32'(2'b01));
    checkOutput("s2_pend0", 32'(statPEND), 32'(2'b10));
    applyStimulus(2'b00, 2'b11, 4'b0000);
    checkOutput("s2_intr_between", 32'(devINTR), 32'(4'b0010));
    checkOutput("s2_vect_between", 32'(devVECT), 32'h0);
    applyStimulus(2'b00, 2'b11, 4'b0000);
    applyStimulus(2'b00, 2'b11, 4'b0010);
    checkOutput("s2_vect1", 32'(devVECT), 32'(18'o000304));
    checkOutput("s2_ack1", 32'(srcACK), 32'(2'b10));
    checkOutput("s2_pend1", 32'(statPEND), 32'h0);
    applyStimulus(2'b00, 2'b11, 4'b0000);
    checkOutput("s2_intr_end", 32'(devINTR), 32'h0);

    // Enable withdrawn before acknowledge
    applyStimulus(2'b01, 2'b11, 4'b0000);
    checkOutput("s3_intr", 32'(devINTR), 32'(4'b0010));
    applyStimulus(2'b00, 2'b10, 4'b0000);
    checkOutput("s3_intr_drop", 32'(devINTR), 32'h0);
    checkOutput("s3_pend_drop", 32'(statPEND), 32'h0);
    applyStimulus(2'b00, 2'b10, 4'b0000);
    applyStimulus(2'b00, 2'b10, 4'b0010);
    checkOutput("s3_late_vectv", 32'(devVECTV), 32'h0);
    checkOutput("s3_late_vect", 32'(devVECT), 32'h0);
    checkOutput("s3_late_ack", 32'(srcACK), 32'h0);
    applyStimulus(2'b00, 2'b11, 4'b0000);

    // Enable dropped in the very cycle INTA arrives: passive release
    applyStimulus(2'b01, 2'b11, 4'b0000);
    applyStimulus(2'b00, 2'b11, 4'b0000);
    applyStimulus(2'b00, 2'b00, 4'b0010);
    checkOutput("race_vectv", 32'(devVECTV), 32'h0);
    checkOutput("race_vect", 32'(devVECT), 32'h0);
    checkOutput("race_ack", 32'(srcACK), 32'h0);
    checkOutput("race_pend", 32'(statPEND), 32'h0);
    applyStimulus(2'b00, 2'b11, 4'b0000);
    checkOutput("race_intr_end", 32'(devINTR), 32'h0);

    // Event during VEC is kept and re-requested
    applyStimulus(2'b01, 2'b11, 4'b0000);
    applyStimulus(2'b00, 2'b11, 4'b0000);
    applyStimulus(2'b00, 2'b11, 4'b0010);
    checkOutput("s4_vect", 32'(devVECT), 32'(18'o000300));
    checkOutput("s4_ack", 32'(srcACK), 32'(2'b01));
    applyStimulus(2'b01, 2'b11, 4'b0010);
    checkOutput("s4_pend_in_vec", 32'(statPEND), 32'(2'b01));
    checkOutput("s4_intr_in_vec", 32'(devINTR), 32'h0);
    checkOutput("s4_vectv_in_vec", 32'(devVECTV), 32'h1);
    applyStimulus(2'b00, 2'b11, 4'b0000);
    checkOutput("s4_rereq", 32'(devINTR), 32'(4'b0010));
    checkOutput("s4_vect_clr", 32'(devVECT), 32'h0);

    // Wrong-level acknowledge is ignored, then reset in VEC
    applyStimulus(2'b00, 2'b11, 4'b0000);
    applyStimulus(2'b00, 2'b11, 4'b1000);
    checkOutput("s5_wrong_vectv", 32'(devVECTV), 32'h0);
    checkOutput("s5_wrong_ack", 32'(srcACK), 32'h0);
    checkOutput("s5_wrong_intr", 32'(devINTR), 32'(4'b0010));
    checkOutput("s5_wrong_pend", 32'(statPEND), 32'(2'b01));
    applyStimulus(2'b00, 2'b11, 4'b0010);
    checkOutput("s5_vect", 32'(devVECT), 32'(18'o000300));
    checkOutput("s5_vectv", 32'(devVECTV), 32'h1);
    #2 rst = 1'b0;
    #1;
    checkOutput("s5_rst_vect", 32'(devVECT), 32'h0);
    checkOutput("s5_rst_vectv", 32'(devVECTV), 32'h0);
    checkOutput("s5_rst_ack", 32'(srcACK), 32'h0);
    checkOutput("s5_rst_intr", 32'(devINTR), 32'h0);
    checkOutput("s5_rst_pend", 32'(statPEND), 32'h0);
    devINTA = 4'b0000;
    #2 rst = 1'b1;
    applyStimulus(2'b00, 2'b11, 4'b0000);
    checkOutput("s5_post_intr", 32'(devINTR), 32'h0);

`ifdef UBA_DEV_INTR_TMO_EN
    // INTA held past the timeout forces IDLE with a one-cycle statTMO
    applyStimulus(2'b01, 2'b11, 4'b0000);
    applyStimulus(2'b00, 2'b11, 4'b0000);
    applyStimulus(2'b00, 2'b11, 4'b0010);
    for (int i = 0; i < 254; i++) applyStimulus(2'b00, 2'b11, 4'b0010);
    checkOutput("tmo_before", 32'(statTMO), 32'h0);
    checkOutput("tmo_vectv_before", 32'(devVECTV), 32'h1);
    applyStimulus(2'b00, 2'b11, 4'b0010);
    checkOutput("tmo_pulse", 32'(statTMO), 32'h1);
    checkOutput("tmo_vectv_after", 32'(devVECTV), 32'h0);
    applyStimulus(2'b00, 2'b11, 4'b0010);
    checkOutput("tmo_pulse_end", 32'(statTMO), 32'h0);
    checkOutput("tmo_pend", 32'(statPEND), 32'h0);
    applyStimulus(2'b00, 2'b11, 4'b0000);
`endif

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/uba_dev_intr.md
Name: uba_dev_intr

Overview:
Device-side interrupt requester for a Unibus device behind the UBA, for example a DZ11 RX/TX pair. It collects interrupt events from NUM_SRC internal sources and holds them as pending flags gated by per-source enables. It raises a single bus-request line on devINTR at level BR_LEVEL. When the UBA interrupt controller returns devINTA on that level, it supplies the vector of the highest-priority pending source and retires that source.

Parameters:
NUM_SRC, 2, number of internal interrupt sources (1..8); index 0 has the highest priority.
BR_LEVEL, 5, bus-request level driven (4..7); selects the devINTR/devINTA bit.
VECT_BASE, 18'o000300, vector of source 0; source i uses VECT_BASE + 4*i.

Ports:
clk  in  1  clock
rst  in  1  reset; asynchronous, active-low
srcEVT  in  NUM_SRC  one-cycle event pulse per source
srcIE  in  NUM_SRC  per-source interrupt enable (level)
devINTR  out  [7:4]  bus request; only bit BR_LEVEL is ever driven high
devINTA  in  [7:4]  interrupt acknowledge from the UBA (registered there, level held during WRU)
devVECT  out  18  interrupt vector; zero when not in VEC state
devVECTV  out  1  vector valid
srcACK  out  NUM_SRC  one-cycle pulse to the serviced source
statPEND  out  NUM_SRC  pending flags, for CSR read-back

Behaviour:
- Reset (rst low, asynchronous): all outputs are 0; state is IDLE; pending is 0.
- Pending bit i, evaluated every clk:
  - Set when srcEVT[i] & srcIE[i].
  - Cleared when srcIE[i] = 0.
  - Cleared in the cycle source i is granted.
  - If set and grant-clear coincide on the same bit, set wins.
  - srcIE = 0 overrides a simultaneous event.
- devINTR[BR_LEVEL] = |(pending & srcIE) while state is IDLE or REQ; it is 0 in VEC state. This output is registered, so there is 1 cycle of latency from the event to the request.
- FSM:
  - IDLE: go to REQ when any pending bit is set.
  - REQ:
    - If pending becomes all-zero (enables dropped), go to IDLE and withdraw the request.
    - If devINTA[BR_LEVEL] = 1, the priority encoder picks the lowest pending index g. Latch devVECT = VECT_BASE + 4*g, set devVECTV = 1, pulse srcACK[g] for 1 cycle, clear pending[g], go to VEC.
    - If devINTA[BR_LEVEL] = 1 while nothing is pending (same-cycle withdrawal race), go to VEC with devVECT = 0, devVECTV = 0 and no srcACK (passive release).
  - VEC: hold devVECT/devVECTV stable while devINTA[BR_LEVEL] = 1. On deassertion, clear devVECT and devVECTV and go to IDLE. Re-request is possible the next cycle.
- devINTA bits other than BR_LEVEL are ignored in every state.
- Vector arithmetic is 18-bit unsigned and wraps modulo 2^18; bits [1:0] are always 0.
- Events arriving in VEC state are kept pending and re-requested after return to IDLE. No event is lost and none is duplicated.
- Reset mid-operation (any state) returns to IDLE and drops the vector and all pending bits immediately.

Optional Feature:
UBA_DEV_INTR_TMO_EN
- Defined: add an 8-bit counter that runs in VEC state.
  - If devINTA is still asserted after 255 cycles, force IDLE and pulse statTMO (extra 1-bit output) for 1 cycle.
  - The pending bit of the granted source stays cleared.
  - The counter resets on every entry to VEC.
- Undefined: no counter and no statTMO port; VEC waits indefinitely.

Decomposition:
- Package uba_intr_pkg:
  - one-hot acknowledge encodings for levels 7..4 (INTR7 = 4'b1000 ... INTR4 = 4'b0001, NUL = 0);
  - FSM state enum {IDLE, REQ, VEC};
  - vector width constant (18).
- Sub-module uba_intr_prienc: NUM_SRC-wide lowest-index priority encoder returning grant index and an any-valid flag. It is purely combinational.

Test Plan:
- Default params: srcIE = 2'b11, pulse srcEVT[1] -> devINTR = 4'b0010 on the next cycle. Assert devINTA = 4'b0010 -> devVECT = 18'o000304, devVECTV = 1, srcACK = 2'b10 for 1 cycle. Drop devINTA -> devINTR = 0, devVECT = 0.
- srcEVT = 2'b11 in the same cycle, then two acknowledge cycles -> first vector 18'o000300 with srcACK[0], second 18'o000304 with srcACK[1]; devINTR stays high between the acknowledges.
- Event on source 0, then srcIE[0] = 0 before acknowledge -> devINTR drops; a later devINTA gives devVECTV = 0, devVECT = 0 and no srcACK.
- srcEVT[0] pulsed during VEC state of a source 0 grant -> statPEND[0] = 1; request reasserts 1 cycle after devINTA drops.
- devINTA = 4'b1000 (wrong level) with BR_LEVEL = 5 -> no state change, no vector. Then rst low in VEC state -> all outputs 0 asynchronously.
- With UBA_DEV_INTR_TMO_EN defined: hold devINTA for 300 cycles -> statTMO pulses at cycle 255 of VEC and devVECTV = 0 thereafter.
